// File: rtl/pll_lock_reset_seq.sv
// PLL reset/lock supervisor: pulses the PLL reset, waits for a stable lock,
// then releases staged active-low system resets and re-resets on lock loss.
module pll_lock_reset_seq #(
    parameter int PLL_RST_CYC  = 16,
    parameter int LOCK_TIMEOUT = 270000,
    parameter int LOCK_STABLE  = 2700,
    parameter int STAGES       = 2,
    parameter int STAGE_GAP    = 64,
    parameter int CNT_W        = 8
) (
    input  logic              clkin,
    input  logic              resetn,
    input  logic              pll_lock,
    output logic              pll_reset,
    output logic [STAGES-1:0] rst_n_out,
    output logic              ready,
    output logic [2:0]        state,
    output logic [CNT_W-1:0]  loss_cnt,
    output logic [CNT_W-1:0]  retry_cnt
);

    localparam int MAX_AB = (PLL_RST_CYC > LOCK_TIMEOUT) ? PLL_RST_CYC : LOCK_TIMEOUT;
    localparam int MAX_CD = (LOCK_STABLE > STAGE_GAP) ? LOCK_STABLE : STAGE_GAP;
    localparam int MAX_C  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int TW     = $clog2(MAX_C + 1);

    localparam logic [TW-1:0] RST_END = TW'(PLL_RST_CYC - 1);
    localparam logic [TW-1:0] TO_END  = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] STB_END = TW'(LOCK_STABLE - 1);
    localparam logic [TW-1:0] GAP_END = TW'(STAGE_GAP - 1);

    if (PLL_RST_CYC < 1 || LOCK_TIMEOUT < 1 || LOCK_STABLE < 1 ||
        STAGE_GAP < 1 || STAGES < 1 || STAGES > 8 || CNT_W < 1) begin : g_bad_param
        $error("pll_lock_reset_seq: parameter out of range");
    end

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4
    } state_t;

    state_t        st;
    logic [TW-1:0] timer;
    logic          sync1;
    logic          lk;
    logic          lost;

    assign state = st;
    assign lost  = !lk && (st == RELEASE || st == RUN);

    always_ff @(posedge clkin) begin
        if (!resetn) begin
            st        <= PLL_RST;
            pll_reset <= 1'b1;
            rst_n_out <= '0;
            ready     <= 1'b0;
            loss_cnt  <= '0;
            retry_cnt <= '0;
            timer     <= '0;
            sync1     <= 1'b0;
            lk        <= 1'b0;
        end else begin
            sync1 <= pll_lock;
            lk    <= sync1;
            if (lost) begin
                // lock loss always forces a fresh PLL reset pulse
                st        <= PLL_RST;
                pll_reset <= 1'b1;
                rst_n_out <= '0;
                ready     <= 1'b0;
                timer     <= '0;
                if (loss_cnt != '1) loss_cnt <= loss_cnt + CNT_W'(1);
            end else begin
                case (st)
                    PLL_RST: begin
                        if (timer == RST_END) begin
                            st        <= WAIT_LOCK;
                            pll_reset <= 1'b0;
                            timer     <= '0;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                    WAIT_LOCK: begin
                        if (lk) begin
                            st    <= STABLE;
                            timer <= '0;
                        end else if (timer == TO_END) begin
                            st        <= PLL_RST;
                            pll_reset <= 1'b1;
                            timer     <= '0;
                            if (retry_cnt != '1) retry_cnt <= retry_cnt + CNT_W'(1);
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                    STABLE: begin
                        if (!lk) begin
                            st    <= WAIT_LOCK;
                            timer <= '0;
                        end else if (timer == STB_END) begin
                            st        <= RELEASE;
                            rst_n_out <= STAGES'(1);
                            timer     <= '0;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                    RELEASE: begin
                        // rst_n_out is a thermometer code; top bit set means done
                        if (rst_n_out[STAGES-1]) begin
                            st    <= RUN;
                            ready <= 1'b1;
                        end else if (timer == GAP_END) begin
                            rst_n_out <= (rst_n_out << 1) | STAGES'(1);
                            timer     <= '0;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                    RUN: begin
                        ready <= 1'b1;
                    end
                    default: begin
                        st        <= PLL_RST;
                        pll_reset <= 1'b1;
                        rst_n_out <= '0;
                        ready     <= 1'b0;
                        timer     <= '0;
                    end
                endcase
            end
        end
    end

endmodule
